// File: rtl/calc_ctrl.sv
// Keypad-command sequencer: builds decimal operands, drives the ALU start/done handshake and
// publishes display value/status. Define CALC_CHAIN_EN to let an operator in ENTER_B chain ops.
module calc_ctrl #(
  parameter int unsigned DATA_W      = 27,
  parameter int unsigned MAX_DIGITS  = 8,
  parameter int unsigned ALU_TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [3:0]        i_cmd,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  output logic              o_alu_start,
  output logic [1:0]        o_alu_op,
  output logic [DATA_W-1:0] o_alu_a,
  output logic [DATA_W-1:0] o_alu_b,
  input  logic              i_alu_done,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_alu_err,
  output logic [DATA_W-1:0] o_disp_value,
  output logic [3:0]        o_disp_digits,
  output logic [1:0]        o_status
);

  localparam logic [2:0] ST_ENTER_A = 3'd0;
  localparam logic [2:0] ST_OP_WAIT = 3'd1;
  localparam logic [2:0] ST_ENTER_B = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_RESULT  = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  localparam int unsigned TMO_W       = $clog2(ALU_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ALU_TIMEOUT - 1);
  localparam logic [3:0]       MAX_CNT  = 4'(MAX_DIGITS);

  logic [2:0]        r_state, w_state_d;
  logic [DATA_W-1:0] r_a, w_a_d, r_b, w_b_d, r_disp, w_disp_d;
  logic [1:0]        r_op, w_op_d, r_status, w_status_d;
  logic [3:0]        r_cnt, w_cnt_d;
  logic [TMO_W-1:0]  r_tmo, w_tmo_d;
  logic              r_start, r_ready;
  logic              w_go, w_acc, w_is_dig, w_is_op, w_is_clr, w_is_eq;
  logic [1:0]        w_cmd_op;
  logic [DATA_W-1:0] w_dig;
`ifdef CALC_CHAIN_EN
  logic              r_chain, w_chain_d;
  logic [1:0]        r_chain_op, w_chain_op_d;
`endif

  assign w_acc    = i_cmd_valid && r_ready;
  assign w_is_dig = (i_cmd <= 4'd9);
  assign w_is_op  = (i_cmd == 4'd10) || (i_cmd == 4'd11) || (i_cmd == 4'd12);
  assign w_is_clr = (i_cmd == 4'd13);
  assign w_is_eq  = (i_cmd == 4'd14);
  assign w_dig    = DATA_W'(i_cmd);
  assign w_cmd_op = (i_cmd == 4'd10) ? 2'b00 : (i_cmd == 4'd11) ? 2'b01 : 2'b10;

  always_comb begin
    w_state_d = r_state;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_op_d    = r_op;
    w_cnt_d   = r_cnt;
    w_tmo_d   = r_tmo;
    w_go      = 1'b0;
`ifdef CALC_CHAIN_EN
    w_chain_d    = r_chain;
    w_chain_op_d = r_chain_op;
`endif
    // r_ready is low only in EXEC, so CLR here never aborts a running operation
    if (w_acc && w_is_clr) begin
      w_a_d     = '0;
      w_b_d     = '0;
      w_cnt_d   = '0;
      w_state_d = ST_ENTER_A;
    end else begin
      unique case (r_state)
        ST_ENTER_A: begin
          if (w_acc && w_is_dig && (r_cnt < MAX_CNT)) begin
            w_a_d   = r_a * DATA_W'(10) + w_dig;
            w_cnt_d = r_cnt + 4'd1;
          end else if (w_acc && w_is_op) begin
            w_op_d    = w_cmd_op;
            w_state_d = ST_OP_WAIT;
          end
        end
        ST_OP_WAIT: begin
          if (w_acc && w_is_dig) begin
            w_b_d     = w_dig;
            w_cnt_d   = 4'd1;
            w_state_d = ST_ENTER_B;
          end else if (w_acc && w_is_op) begin
            w_op_d = w_cmd_op;
          end else if (w_acc && w_is_eq) begin
            w_b_d = r_a;
            w_go  = 1'b1;
          end
        end
        ST_ENTER_B: begin
          if (w_acc && w_is_dig && (r_cnt < MAX_CNT)) begin
            w_b_d   = r_b * DATA_W'(10) + w_dig;
            w_cnt_d = r_cnt + 4'd1;
          end else if (w_acc && w_is_eq) begin
            w_go = 1'b1;
          end
`ifdef CALC_CHAIN_EN
          else if (w_acc && w_is_op) begin
            w_chain_d    = 1'b1;
            w_chain_op_d = w_cmd_op;
            w_go         = 1'b1;
          end
`endif
        end
        ST_EXEC: begin
          if (i_alu_done && i_alu_err) begin
            w_state_d = ST_ERROR;
          end else if (i_alu_done) begin
            w_a_d     = i_alu_result;
            w_state_d = ST_RESULT;
`ifdef CALC_CHAIN_EN
            if (r_chain) begin
              w_op_d    = r_chain_op;
              w_state_d = ST_OP_WAIT;
            end
`endif
          end else if (r_tmo == TMO_LAST) begin
            w_state_d = ST_ERROR;
          end else if (r_tmo != '1) begin
            w_tmo_d = r_tmo + 1'b1;
          end
`ifdef CALC_CHAIN_EN
          if (w_state_d != ST_EXEC) w_chain_d = 1'b0;
`endif
        end
        ST_RESULT: begin
          if (w_acc && w_is_dig) begin
            w_a_d     = w_dig;
            w_cnt_d   = 4'd1;
            w_state_d = ST_ENTER_A;
          end else if (w_acc && w_is_op) begin
            w_op_d    = w_cmd_op;
            w_state_d = ST_OP_WAIT;
          end else if (w_acc && w_is_eq) begin
            w_go = 1'b1;
          end
        end
        ST_ERROR: ;
        default: w_state_d = ST_ENTER_A;
      endcase
    end
    if (w_go) begin
      w_state_d = ST_EXEC;
      w_tmo_d   = '0;
    end
  end

  always_comb begin
    w_disp_d   = w_a_d;
    w_status_d = 2'b00;
    unique case (w_state_d)
      ST_ENTER_B: w_disp_d = w_b_d;
      ST_EXEC:    w_status_d = 2'b01;
      ST_RESULT:  w_status_d = 2'b10;
      ST_ERROR: begin
        w_disp_d   = '0;
        w_status_d = 2'b11;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_ENTER_A;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 2'b00;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_start  <= 1'b0;
      r_ready  <= 1'b1;
      r_disp   <= '0;
      r_status <= 2'b00;
`ifdef CALC_CHAIN_EN
      r_chain    <= 1'b0;
      r_chain_op <= 2'b00;
`endif
    end else begin
      r_state  <= w_state_d;
      r_a      <= w_a_d;
      r_b      <= w_b_d;
      r_op     <= w_op_d;
      r_cnt    <= w_cnt_d;
      r_tmo    <= w_tmo_d;
      r_start  <= w_go;
      r_ready  <= (w_state_d != ST_EXEC);
      r_disp   <= w_disp_d;
      r_status <= w_status_d;
`ifdef CALC_CHAIN_EN
      r_chain    <= w_chain_d;
      r_chain_op <= w_chain_op_d;
`endif
    end
  end

  assign o_cmd_ready   = r_ready;
  assign o_alu_start   = r_start;
  assign o_alu_op      = r_op;
  assign o_alu_a       = r_a;
  assign o_alu_b       = r_b;
  assign o_disp_value  = r_disp;
  assign o_disp_digits = r_cnt;
  assign o_status      = r_status;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: key-entry vector table plus hand-written ALU handshake sequences.
module tb_calc_ctrl;

  localparam int unsigned DW = 27;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    cmd = 4'd0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready, alu_start;
  logic [1:0]    alu_op, status;
  logic [DW-1:0] alu_a, alu_b, disp_value;
  logic          alu_done = 1'b0;
  logic [DW-1:0] alu_result = '0;
  logic          alu_err = 1'b0;
  logic [3:0]    disp_digits;

  int n_checks = 0;
  int n_fail   = 0;
  int n_starts;

  localparam logic [3:0] K_ADD = 4'd10, K_SUB = 4'd11, K_MUL = 4'd12;
  localparam logic [3:0] K_CLR = 4'd13, K_EQ = 4'd14, K_NOP = 4'd15;

  calc_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_cmd        (cmd),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .o_alu_start  (alu_start),
    .o_alu_op     (alu_op),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .i_alu_done   (alu_done),
    .i_alu_result (alu_result),
    .i_alu_err    (alu_err),
    .o_disp_value (disp_value),
    .o_disp_digits(disp_digits),
    .o_status     (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  key;
    logic [31:0] disp;
    logic [3:0]  digits;
    logic [1:0]  stat;
    logic        chk_op;
    logic [1:0]  op;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Presses one key; returns at the negedge after the accepting posedge.
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    cmd       = k;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (alu_start) n_starts++;
  endtask

  task automatic done_pulse(input logic [DW-1:0] res, input logic err);
    alu_done   = 1'b1;
    alu_result = res;
    alu_err    = err;
    @(negedge clk);
    alu_done = 1'b0;
    alu_err  = 1'b0;
  endtask

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{4'd1,  1,        1, 2'b00, 1'b0, 2'b00};
    vecs[1]  = '{4'd2,  12,       2, 2'b00, 1'b0, 2'b00};
    vecs[2]  = '{4'd3,  123,      3, 2'b00, 1'b0, 2'b00};
    vecs[3]  = '{4'd4,  1234,     4, 2'b00, 1'b0, 2'b00};
    vecs[4]  = '{4'd5,  12345,    5, 2'b00, 1'b0, 2'b00};
    vecs[5]  = '{4'd6,  123456,   6, 2'b00, 1'b0, 2'b00};
    vecs[6]  = '{4'd7,  1234567,  7, 2'b00, 1'b0, 2'b00};
    vecs[7]  = '{4'd8,  12345678, 8, 2'b00, 1'b0, 2'b00};
    vecs[8]  = '{4'd9,  12345678, 8, 2'b00, 1'b0, 2'b00};
    vecs[9]  = '{K_NOP, 12345678, 8, 2'b00, 1'b0, 2'b00};
    vecs[10] = '{K_EQ,  12345678, 8, 2'b00, 1'b0, 2'b00};
    vecs[11] = '{K_ADD, 12345678, 8, 2'b00, 1'b1, 2'b00};
    vecs[12] = '{K_SUB, 12345678, 8, 2'b00, 1'b1, 2'b01};
    vecs[13] = '{4'd4,  4,        1, 2'b00, 1'b1, 2'b01};
    vecs[14] = '{4'd2,  42,       2, 2'b00, 1'b1, 2'b01};

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_status", 32'(status), 0);
    check("rst_disp", 32'(disp_value), 0);
    check("rst_digits", 32'(disp_digits), 0);
    check("rst_start", 32'(alu_start), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    rst_n = 1'b1;

    n_starts = 0;
    for (int i = 0; i < 15; i++) begin
      press(vecs[i].key);
      check($sformatf("vec%0d_disp", i), 32'(disp_value), vecs[i].disp);
      check($sformatf("vec%0d_digits", i), 32'(disp_digits), 32'(vecs[i].digits));
      check($sformatf("vec%0d_status", i), 32'(status), 32'(vecs[i].stat));
      if (vecs[i].chk_op) check($sformatf("vec%0d_op", i), 32'(alu_op), 32'(vecs[i].op));
    end
    press(K_CLR);
    check("clr_disp", 32'(disp_value), 0);
    check("clr_digits", 32'(disp_digits), 0);

    // 12345 + 6789 with a 5-cycle ALU
    n_starts = 0;
    press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(K_ADD);
    press(4'd6); press(4'd7); press(4'd8); press(4'd9); press(K_EQ);
    check("add_start", 32'(alu_start), 1);
    check("add_a", 32'(alu_a), 12345);
    check("add_b", 32'(alu_b), 6789);
    check("add_op", 32'(alu_op), 0);
    check("add_busy", 32'(status), 1);
    check("add_ready", 32'(cmd_ready), 0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      if (alu_start) n_starts++;
    end
    done_pulse(27'd19134, 1'b0);
    if (alu_start) n_starts++;
    check("add_starts", 32'(n_starts), 1);
    check("add_status", 32'(status), 2);
    check("add_disp", 32'(disp_value), 19134);

    // 7*7, done in the start cycle, then repeat with EQ; command during EXEC is dropped
    press(K_CLR); press(4'd7); press(K_MUL); press(K_EQ);
    check("mul_a", 32'(alu_a), 7);
    check("mul_b", 32'(alu_b), 7);
    check("mul_op", 32'(alu_op), 2);
    check("mul_start", 32'(alu_start), 1);
    done_pulse(27'd49, 1'b0);
    check("mul_status", 32'(status), 2);
    check("mul_disp", 32'(disp_value), 49);
    press(K_EQ);
    check("rep_start", 32'(alu_start), 1);
    check("rep_a", 32'(alu_a), 49);
    check("rep_b", 32'(alu_b), 7);
    check("rep_ready", 32'(cmd_ready), 0);
    press(K_CLR);
    check("drop_status", 32'(status), 1);
    check("drop_start", 32'(alu_start), 0);
    done_pulse(27'd343, 1'b1);
    check("err_status", 32'(status), 3);
    check("err_disp", 32'(disp_value), 0);

    // Timeout: no done for ALU_TIMEOUT cycles
    press(K_CLR); press(4'd7); press(K_ADD); press(K_EQ);
    check("tmo_start", 32'(alu_start), 1);
    repeat (63) @(negedge clk);
    check("tmo_busy_last", 32'(status), 1);
    @(negedge clk);
    check("tmo_status", 32'(status), 3);
    check("tmo_disp", 32'(disp_value), 0);
    press(4'd5);
    check("err_digit_status", 32'(status), 3);
    check("err_digit_disp", 32'(disp_value), 0);
    press(K_CLR);
    check("err_clr_status", 32'(status), 0);
    check("err_clr_disp", 32'(disp_value), 0);

    // Reset in the middle of EXEC, then a stale done
    press(4'd3); press(K_ADD); press(4'd4); press(K_EQ);
    check("rx_start", 32'(alu_start), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rx_status", 32'(status), 0);
    check("rx_start0", 32'(alu_start), 0);
    check("rx_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n    = 1'b1;
    n_starts = 0;
    done_pulse(27'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (alu_start) n_starts++;
      @(negedge clk);
    end
    check("rx_no_start", 32'(n_starts), 0);
    check("rx_late_status", 32'(status), 0);
    check("rx_late_disp", 32'(disp_value), 0);

`ifdef CALC_CHAIN_EN
    press(4'd2); press(K_ADD); press(4'd3); press(K_SUB);
    check("chain_start", 32'(alu_start), 1);
    check("chain_a", 32'(alu_a), 2);
    check("chain_b", 32'(alu_b), 3);
    check("chain_op_run", 32'(alu_op), 0);
    done_pulse(27'd5, 1'b0);
    check("chain_status", 32'(status), 0);
    check("chain_op", 32'(alu_op), 1);
    check("chain_disp", 32'(disp_value), 5);
`else
    n_starts = 0;
    press(4'd2); press(K_ADD); press(4'd3); press(K_SUB);
    check("nochain_start", 32'(n_starts), 0);
    check("nochain_status", 32'(status), 0);
    check("nochain_disp", 32'(disp_value), 3);
    check("nochain_op", 32'(alu_op), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
